// File: rtl/alu_pkg.sv
// Shared ALU op, SrcA select and forward select types.
// Imported by ex_operand_stage and fwd_sel.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_REG  = 2'b00,
        SRCA_PC   = 2'b01,
        SRCA_ZERO = 2'b10
    } srca_sel_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_e;

    localparam int REG_IDX_W = 5;

    // x0 is hardwired zero, so a write to it is never a forwarding source
    function automatic logic idx_hit(
        input logic                 en,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs
    );
        return en && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_sel.sv
// fwd_sel: forward selection for one source operand (MEM beats WB).
// Ports: i_rs/i_reg (index, register value), i_*_m / i_*_w (stage rd, we, value), o_sel, o_val.
module fwd_sel
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic [4:0]         i_rs,
    input  logic [D_WIDTH-1:0] i_reg,
    input  logic [4:0]         i_rd_m,
    input  logic               i_we_m,
    input  logic [D_WIDTH-1:0] i_val_m,
    input  logic [4:0]         i_rd_w,
    input  logic               i_we_w,
    input  logic [D_WIDTH-1:0] i_val_w,
    output fwd_sel_e           o_sel,
    output logic [D_WIDTH-1:0] o_val
);

    always_comb begin
        o_sel = FWD_NONE;
        if (idx_hit(i_we_m, i_rd_m, i_rs)) begin
            o_sel = FWD_M;
        end else if (idx_hit(i_we_w, i_rd_w, i_rs)) begin
            o_sel = FWD_W;
        end
    end

    always_comb begin
        o_val = i_reg;
        case (o_sel)
            FWD_M:   o_val = i_val_m;
            FWD_W:   o_val = i_val_w;
            default: o_val = i_reg;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with stall/flush, MEM/WB forwarding and ALU operand muxes.
// Ports: D-side decode fields in, M/W forwarding sources in, SrcAE/SrcBE/ALUControlE/WriteDataE
// and registered RdE/Rs1E/Rs2E/RegWriteE/ValidE out. Macro FORWARDING_EN enables forwarding.
module ex_operand_stage
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               StallE,
    input  logic               FlushE,
    input  logic               ValidD,
    input  logic [D_WIDTH-1:0] RD1D,
    input  logic [D_WIDTH-1:0] RD2D,
    input  logic [D_WIDTH-1:0] ImmExtD,
    input  logic [D_WIDTH-1:0] PCD,
    input  logic [4:0]         Rs1D,
    input  logic [4:0]         Rs2D,
    input  logic [4:0]         RdD,
    input  logic [3:0]         ALUControlD,
    input  logic [1:0]         ALUSrcAD,
    input  logic               ALUSrcBD,
    input  logic               RegWriteD,
    input  logic [4:0]         RdM,
    input  logic [4:0]         RdW,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic [D_WIDTH-1:0] ALUResultM,
    input  logic [D_WIDTH-1:0] ResultW,
    output logic [D_WIDTH-1:0] SrcAE,
    output logic [D_WIDTH-1:0] SrcBE,
    output logic [3:0]         ALUControlE,
    output logic [D_WIDTH-1:0] WriteDataE,
    output logic [4:0]         RdE,
    output logic [4:0]         Rs1E,
    output logic [4:0]         Rs2E,
    output logic               RegWriteE,
    output logic               ValidE
);

    logic               r_valid;
    logic               r_regwrite;
    logic [4:0]         r_rd;
    logic [4:0]         r_rs1;
    logic [4:0]         r_rs2;
    logic [3:0]         r_aluctl;
    logic [1:0]         r_srca_sel;
    logic               r_srcb_sel;
    logic [D_WIDTH-1:0] r_rd1;
    logic [D_WIDTH-1:0] r_rd2;
    logic [D_WIDTH-1:0] r_imm;
    logic [D_WIDTH-1:0] r_pc;

    fwd_sel_e           w_a_sel;
    fwd_sel_e           w_b_sel;
    logic [D_WIDTH-1:0] w_a_val;
    logic [D_WIDTH-1:0] w_b_val;
    logic [D_WIDTH-1:0] w_fwd_a;
    logic [D_WIDTH-1:0] w_fwd_b;
    logic               w_unused_sink;

    // Reset and flush both leave a bubble that issues ADD on zero operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_aluctl   <= ALU_ADD;
            r_srca_sel <= SRCA_REG;
            r_srcb_sel <= 1'b0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
        end else if (FlushE) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_aluctl   <= ALU_ADD;
            r_srca_sel <= SRCA_REG;
            r_srcb_sel <= 1'b0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
        end else if (!StallE) begin
            r_valid    <= ValidD;
            r_regwrite <= RegWriteD & ValidD;
            r_rd       <= RdD;
            r_rs1      <= Rs1D;
            r_rs2      <= Rs2D;
            r_aluctl   <= ALUControlD;
            r_srca_sel <= ALUSrcAD;
            r_srcb_sel <= ALUSrcBD;
            r_rd1      <= RD1D;
            r_rd2      <= RD2D;
            r_imm      <= ImmExtD;
            r_pc       <= PCD;
        end
    end

    fwd_sel #(.D_WIDTH(D_WIDTH)) u_fwd_a (
        .i_rs    (r_rs1),
        .i_reg   (r_rd1),
        .i_rd_m  (RdM),
        .i_we_m  (RegWriteM),
        .i_val_m (ALUResultM),
        .i_rd_w  (RdW),
        .i_we_w  (RegWriteW),
        .i_val_w (ResultW),
        .o_sel   (w_a_sel),
        .o_val   (w_a_val)
    );

    fwd_sel #(.D_WIDTH(D_WIDTH)) u_fwd_b (
        .i_rs    (r_rs2),
        .i_reg   (r_rd2),
        .i_rd_m  (RdM),
        .i_we_m  (RegWriteM),
        .i_val_m (ALUResultM),
        .i_rd_w  (RdW),
        .i_we_w  (RegWriteW),
        .i_val_w (ResultW),
        .o_sel   (w_b_sel),
        .o_val   (w_b_val)
    );

`ifdef FORWARDING_EN
    assign w_fwd_a       = w_a_val;
    assign w_fwd_b       = w_b_val;
    assign w_unused_sink = ^{w_a_sel, w_b_sel};
`else
    // Hazard unit stalls on every RAW hazard, so the register values are final
    assign w_fwd_a       = r_rd1;
    assign w_fwd_b       = r_rd2;
    assign w_unused_sink = ^{w_a_sel, w_b_sel, w_a_val, w_b_val};
`endif

    always_comb begin
        SrcAE = '0;
        case (r_srca_sel)
            SRCA_REG: SrcAE = w_fwd_a;
            SRCA_PC:  SrcAE = r_pc;
            default:  SrcAE = '0;
        endcase
    end

    assign SrcBE       = r_srcb_sel ? r_imm : w_fwd_b;
    assign WriteDataE  = w_fwd_b;
    assign ALUControlE = r_aluctl;
    assign RdE         = r_rd;
    assign Rs1E        = r_rs1;
    assign Rs2E        = r_rs2;
    assign RegWriteE   = r_regwrite;
    assign ValidE      = r_valid;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that feeds the execute-stage ALU. It captures the decoded instruction fields each cycle and supports stall and flush. It resolves RAW hazards by forwarding from the MEM and WB stages, then drives SrcA, SrcB and ALUControl straight into the ALU. It also produces the forwarded store data and the EX-stage destination info used by the hazard unit.

## Interface
- D_WIDTH, 32, datapath width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- StallE  in  1  hold ID/EX register contents
- FlushE  in  1  load a bubble into ID/EX
- ValidD  in  1  decode slot holds a real instruction
- RD1D, RD2D  in  D_WIDTH  register-file read data
- ImmExtD, PCD  in  D_WIDTH  extended immediate, instruction PC
- Rs1D, Rs2D, RdD  in  5  source/destination register indices
- ALUControlD  in  4  ALU op, encoding from alu_pkg
- ALUSrcAD  in  2  SrcA select: 00 reg, 01 PC, 10 zero
- ALUSrcBD  in  1  SrcB select: 0 reg, 1 immediate
- RegWriteD  in  1  instruction writes Rd
- RdM, RdW  in  5  MEM/WB destination indices
- RegWriteM, RegWriteW  in  1  MEM/WB write enables, already valid-qualified
- ALUResultM, ResultW  in  D_WIDTH  MEM/WB forwarding values
- SrcAE, SrcBE  out  D_WIDTH  ALU operands
- ALUControlE  out  4  ALU op
- WriteDataE  out  D_WIDTH  forwarded rs2 used as store data
- RdE, Rs1E, Rs2E  out  5  registered indices for the hazard unit
- RegWriteE, ValidE  out  1  registered control

## Operation
- ID/EX register update on each rising clk edge, in priority order:
  - FlushE=1: ValidE, RegWriteE and all indices cleared; ALUControlE=ADD; data fields zeroed.
  - StallE=1 (and FlushE=0): all fields hold.
  - Otherwise: all fields load from the D-side inputs. RegWriteE loads RegWriteD&ValidD.
- Forward select per source operand (rs1, rs2), evaluated combinationally on the registered Rs1E/Rs2E:
  - FWD_M when RegWriteM, RdM!=0 and RdM==RsXE.
  - Else FWD_W when RegWriteW, RdW!=0 and RdW==RsXE.
  - Else FWD_NONE, which uses the registered RD1E/RD2E.
  - M beats W when both match. x0 is never forwarded.
- Forwarded rs1 is fwdA; forwarded rs2 is fwdB.
- SrcAE by ALUSrcAE: 00 fwdA, 01 PCE (AUIPC, JAL), 10 zero (LUI), 11 zero.
- SrcBE = ALUSrcBE ? ImmExtE : fwdB.
- WriteDataE = fwdB, regardless of ALUSrcBE.
- All arithmetic is D_WIDTH bits with no truncation or extension. Indices are 5 bits.

## Timing
- Reset values (asynchronous, immediate on rst):
  - ValidE=0, RegWriteE=0, RdE=Rs1E=Rs2E=0, ALUControlE=4'b0000 (ADD).
  - All data registers 0.
  - Resulting outputs: SrcAE=0, SrcBE=0, WriteDataE=0.
- Latency: D-side inputs appear on the E-side one cycle later.
- Forwarding and operand muxes are zero-latency, combinational from the E registers and the M/W inputs.
- StallE with FlushE in the same cycle: the flush wins.
- Stall: E-side outputs may still change during a held cycle as M/W forwarding sources update. Holding is on register contents only.
- Reset mid-stall clears the stage. The instruction held by the stall is lost, and the upstream pipeline restarts from reset.
- A bubble (ValidE=0) still drives ALU operands but must never assert RegWriteE.

## Configuration
- FORWARDING_EN defined: forwarding muxes active as described.
- Not defined:
  - fwdA=RD1E, fwdB=RD2E, and the M/W forwarding ports are ignored.
  - The hazard unit must stall on every RAW hazard.
  - All other behaviour is unchanged.

## Structure
- Shared package alu_pkg holds:
  - alu_op_e: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - srca_sel_e (REG, PC, ZERO).
  - fwd_sel_e (FWD_NONE, FWD_W, FWD_M).
- Sub-module fwd_sel: one instance per source operand. Takes RsXE plus the M/W index/enable/data inputs, returns fwd_sel_e and the forwarded value.

## Test plan
- Reset:
  - Assert rst mid-run -> ValidE=0, RegWriteE=0, ALUControlE=0, SrcAE=SrcBE=WriteDataE=0 immediately.
  - Deassert rst -> first cycle loads the D-side.
- Pass-through:
  - D: RD1D=5, ImmExtD=7, ALUSrcBD=1, ALUControlD=ADD -> next cycle SrcAE=5, SrcBE=7, ALUControlE=0000.
- Forward priority:
  - Rs1E=3, RdM=3/RegWriteM=1/ALUResultM=0x11, RdW=3/RegWriteW=1/ResultW=0x22 -> SrcAE=0x11.
  - Drop RegWriteM -> SrcAE=0x22.
- x0 guard:
  - Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0xFFFF -> WriteDataE=RD2E, not 0xFFFF.
- Stall/flush:
  - StallE=1 for 3 cycles with changing D inputs -> E registers constant.
  - StallE=1 and FlushE=1 together -> next cycle ValidE=0, RegWriteE=0.
- LUI/AUIPC:
  - ALUSrcAD=10 with ImmExtD=0x12345000 -> SrcAE=0, SrcBE=0x12345000.
  - ALUSrcAD=01 with PCD=0x100 -> SrcAE=0x100.
